control_fsm: RTL and testbench

Multicycle control unit that drives the 16-bit ALU/register-file datapath in place of the board switches. It fetches 16-bit instruction words over a simple request/valid handshake, decodes the CR16-style baseline format, and issues register addresses, ALU control, immediate value, mux selects and write enables. It owns the program counter and sits between instruction memory and the datapath.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/instr_decode.sv | 71 +++++++
 rtl/control_fsm.sv | 158 +++++++++++++++
 tb/tb_control_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction op/ext codes, ALU operation codes and the
// control-unit state enum. The alu module consumes the same ALU_* codes.
package cpu_pkg;

   localparam logic [3:0] OP_RR    = 4'b0000;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   localparam logic [3:0] CODE_ADD = 4'b0101;
   localparam logic [3:0] CODE_SUB = 4'b1001;
   localparam logic [3:0] CODE_CMP = 4'b1011;
   localparam logic [3:0] CODE_AND = 4'b0001;
   localparam logic [3:0] CODE_OR  = 4'b0010;
   localparam logic [3:0] CODE_XOR = 4'b0011;
   localparam logic [3:0] CODE_MOV = 4'b1101;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_CMP  = 5'd2;
   localparam logic [4:0] ALU_AND  = 5'd3;
   localparam logic [4:0] ALU_OR   = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_MOV  = 5'd6;
   localparam logic [4:0] ALU_LUI  = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DECODE  = 2'd2,
      ST_EXECUTE = 2'd3
   } state_t;

   // Same code table serves ext (register form) and op (immediate form).
   // Returns {defined, aluControl}.
   function automatic logic [5:0] code_to_alu(input logic [3:0] code);
      case (code)
         CODE_ADD: return {1'b1, ALU_ADD};
         CODE_SUB: return {1'b1, ALU_SUB};
         CODE_CMP: return {1'b1, ALU_CMP};
         CODE_AND: return {1'b1, ALU_AND};
         CODE_OR:  return {1'b1, ALU_OR};
         CODE_XOR: return {1'b1, ALU_XOR};
         CODE_MOV: return {1'b1, ALU_MOV};
         default:  return 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one baseline instruction word into datapath controls.
module instr_decode
   import cpu_pkg::*;
#(
   parameter int REG_WIDTH     = 16,
   parameter int REG_ADDR_BITS = 4
) (
   input  logic [REG_WIDTH-1:0]     instr,
   output logic [REG_ADDR_BITS-1:0] rdest,
   output logic [REG_ADDR_BITS-1:0] rsrc,
   output logic [4:0]               alu_control,
   output logic [REG_WIDTH-1:0]     immediate,
   output logic                     b_sel,
   output logic                     reg_we,
   output logic                     flag_we,
   output logic                     illegal
);

   logic [3:0] op;
   logic [3:0] ext;
   logic [7:0] imm8;
   logic [5:0] rr_map;
   logic [5:0] im_map;

   assign op     = instr[15:12];
   assign ext    = instr[7:4];
   assign imm8   = instr[7:0];
   assign rdest  = REG_ADDR_BITS'(instr[11:8]);
   assign rsrc   = REG_ADDR_BITS'(instr[3:0]);
   assign rr_map = code_to_alu(ext);
   assign im_map = code_to_alu(op);

   always_comb begin
      alu_control = ALU_ADD;
      immediate   = '0;
      b_sel       = 1'b0;
      reg_we      = 1'b0;
      flag_we     = 1'b0;
      illegal     = 1'b0;
      // An all-zero word is NOP: every control stays at its default.
      if (instr[15:0] != 16'h0000) begin
         if (op == OP_RR) begin
            if (rr_map[5]) begin
               alu_control = rr_map[4:0];
               reg_we      = (rr_map[4:0] != ALU_CMP);
               flag_we     = (rr_map[4:0] <= ALU_CMP);
            end else begin
               illegal = 1'b1;
            end
         end else if (op == OP_LUI) begin
            alu_control = ALU_LUI;
            immediate   = REG_WIDTH'({imm8, 8'h00});
            b_sel       = 1'b1;
            reg_we      = 1'b1;
         end else if (im_map[5]) begin
            alu_control = im_map[4:0];
            b_sel       = 1'b1;
            reg_we      = (im_map[4:0] != ALU_CMP);
            flag_we     = (im_map[4:0] <= ALU_CMP);
            // Arithmetic immediates are signed, logical/move ones unsigned.
            if (im_map[4:0] <= ALU_CMP)
               immediate = {{(REG_WIDTH-8){imm8[7]}}, imm8};
            else
               immediate = REG_WIDTH'(imm8);
         end else begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: fetch handshake, decode, one-cycle execute strobes,
// program counter. Every output comes straight from a flop.
module control_fsm
   import cpu_pkg::*;
#(
   parameter int REG_WIDTH     = 16,
   parameter int REG_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run,
   input  logic                     fetchValid,
   input  logic [REG_WIDTH-1:0]     fetchData,
   output logic                     fetchReq,
   output logic [REG_WIDTH-1:0]     fetchAddr,
   output logic [REG_ADDR_BITS-1:0] regAddressA,
   output logic [REG_ADDR_BITS-1:0] regAddressB,
   output logic [4:0]               aluControl,
   output logic [REG_WIDTH-1:0]     immediate,
   output logic                     aluInputBMuxSelect,
   output logic                     regWriteEnable,
   output logic                     flagWriteEnable,
   output logic                     illegal,
   output logic                     busy
);

   state_t                   state_q, state_d;
   logic [REG_WIDTH-1:0]     pc_q, pc_d;
   logic                     fetch_req_q, fetch_req_d;
   logic                     busy_q, busy_d;
   logic [REG_ADDR_BITS-1:0] ra_q, ra_d, rb_q, rb_d;
   logic [4:0]               alu_q, alu_d;
   logic [REG_WIDTH-1:0]     imm_q, imm_d;
   logic                     bsel_q, bsel_d;
   logic                     rwe_q, rwe_d, fwe_q, fwe_d;
   logic                     illegal_q, illegal_d;
   logic                     pend_rwe_q, pend_rwe_d;
   logic                     pend_fwe_q, pend_fwe_d;
   logic                     pend_ill_q, pend_ill_d;

   logic [REG_ADDR_BITS-1:0] dec_ra, dec_rb;
   logic [4:0]               dec_alu;
   logic [REG_WIDTH-1:0]     dec_imm;
   logic                     dec_bsel, dec_rwe, dec_fwe, dec_ill;

   instr_decode #(
      .REG_WIDTH     (REG_WIDTH),
      .REG_ADDR_BITS (REG_ADDR_BITS)
   ) u_decode (
      .instr       (fetchData),
      .rdest       (dec_ra),
      .rsrc        (dec_rb),
      .alu_control (dec_alu),
      .immediate   (dec_imm),
      .b_sel       (dec_bsel),
      .reg_we      (dec_rwe),
      .flag_we     (dec_fwe),
      .illegal     (dec_ill)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      alu_d      = alu_q;
      imm_d      = imm_q;
      bsel_d     = bsel_q;
      illegal_d  = illegal_q;
      pend_rwe_d = pend_rwe_q;
      pend_fwe_d = pend_fwe_q;
      pend_ill_d = pend_ill_q;
      rwe_d      = 1'b0;
      fwe_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         // The fetched word is decoded on the accepting edge, so the datapath
         // controls are already presented during DECODE and held in EXECUTE.
         ST_FETCH: begin
            if (fetchValid) begin
               state_d    = ST_DECODE;
               ra_d       = dec_ra;
               rb_d       = dec_rb;
               alu_d      = dec_alu;
               imm_d      = dec_imm;
               bsel_d     = dec_bsel;
               pend_rwe_d = dec_rwe;
               pend_fwe_d = dec_fwe;
               pend_ill_d = dec_ill;
            end
         end
         ST_DECODE: begin
            state_d   = ST_EXECUTE;
            rwe_d     = pend_rwe_q;
            fwe_d     = pend_fwe_q;
            illegal_d = illegal_q | pend_ill_q;
         end
         ST_EXECUTE: begin
            pc_d    = pc_q + REG_WIDTH'(1);
            state_d = run ? ST_FETCH : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      fetch_req_d = (state_d == ST_FETCH);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         fetch_req_q <= 1'b0;
         busy_q      <= 1'b0;
         ra_q        <= '0;
         rb_q        <= '0;
         alu_q       <= ALU_ADD;
         imm_q       <= '0;
         bsel_q      <= 1'b0;
         rwe_q       <= 1'b0;
         fwe_q       <= 1'b0;
         illegal_q   <= 1'b0;
         pend_rwe_q  <= 1'b0;
         pend_fwe_q  <= 1'b0;
         pend_ill_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fetch_req_q <= fetch_req_d;
         busy_q      <= busy_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         alu_q       <= alu_d;
         imm_q       <= imm_d;
         bsel_q      <= bsel_d;
         rwe_q       <= rwe_d;
         fwe_q       <= fwe_d;
         illegal_q   <= illegal_d;
         pend_rwe_q  <= pend_rwe_d;
         pend_fwe_q  <= pend_fwe_d;
         pend_ill_q  <= pend_ill_d;
      end
   end

   assign fetchReq           = fetch_req_q;
   assign fetchAddr          = pc_q;
   assign regAddressA        = ra_q;
   assign regAddressB        = rb_q;
   assign aluControl         = alu_q;
   assign immediate          = imm_q;
   assign aluInputBMuxSelect = bsel_q;
   assign regWriteEnable     = rwe_q;
   assign flagWriteEnable    = fwe_q;
   assign illegal            = illegal_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: one task per scenario, hand-computed expectations.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        fetchValid;
   logic [15:0] fetchData;
   logic        fetchReq;
   logic [15:0] fetchAddr;
   logic [3:0]  regAddressA;
   logic [3:0]  regAddressB;
   logic [4:0]  aluControl;
   logic [15:0] immediate;
   logic        aluInputBMuxSelect;
   logic        regWriteEnable;
   logic        flagWriteEnable;
   logic        illegal;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   control_fsm #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .run                (run),
      .fetchValid         (fetchValid),
      .fetchData          (fetchData),
      .fetchReq           (fetchReq),
      .fetchAddr          (fetchAddr),
      .regAddressA        (regAddressA),
      .regAddressB        (regAddressB),
      .aluControl         (aluControl),
      .immediate          (immediate),
      .aluInputBMuxSelect (aluInputBMuxSelect),
      .regWriteEnable     (regWriteEnable),
      .flagWriteEnable    (flagWriteEnable),
      .illegal            (illegal),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one word while in FETCH; returns sampled in EXECUTE.
   task automatic exec_instr(input logic [15:0] w);
      fetchData  = w;
      fetchValid = 1'b1;
      tick();
      fetchValid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; fetchValid = 1'b0; fetchData = 16'h0;
      #2;
      n_cmp++;
      if ({fetchReq, busy, regWriteEnable, flagWriteEnable, aluInputBMuxSelect, illegal} !== 6'b0) begin
         n_bad++; $display("FAIL reset_ctl got %b want 000000", {fetchReq, busy, regWriteEnable, flagWriteEnable, aluInputBMuxSelect, illegal});
      end
      n_cmp++;
      if ({fetchAddr, regAddressA, regAddressB, aluControl, immediate} !== 45'd0) begin
         n_bad++; $display("FAIL reset_data addr=%h ra=%h rb=%h alu=%h imm=%h want 0", fetchAddr, regAddressA, regAddressB, aluControl, immediate);
      end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || fetchReq !== 1'b0) begin
         n_bad++; $display("FAIL idle_no_run busy=%b req=%b want 0 0", busy, fetchReq);
      end
   endtask

   task automatic test_add();
      run = 1'b1;
      tick();
      n_cmp++;
      if ({fetchReq, busy, fetchAddr} !== {1'b1, 1'b1, 16'h0000}) begin
         n_bad++; $display("FAIL add_fetch req=%b busy=%b addr=%h want 1 1 0000", fetchReq, busy, fetchAddr);
      end
      fetchData = 16'h0351; fetchValid = 1'b1;
      tick();
      fetchValid = 1'b0;
      n_cmp++;
      if ({regAddressA, regAddressB, aluControl, regWriteEnable, fetchReq} !== {4'd3, 4'd1, 5'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_decode ra=%0d rb=%0d alu=%0d we=%b req=%b want 3 1 0 0 0", regAddressA, regAddressB, aluControl, regWriteEnable, fetchReq);
      end
      tick();
      n_cmp++;
      if ({regAddressA, regAddressB, aluControl, regWriteEnable, flagWriteEnable, aluInputBMuxSelect} !== {4'd3, 4'd1, 5'd0, 1'b1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL add_exec ra=%0d rb=%0d alu=%0d we=%b fe=%b sel=%b want 3 1 0 1 1 0", regAddressA, regAddressB, aluControl, regWriteEnable, flagWriteEnable, aluInputBMuxSelect);
      end
      tick();
      n_cmp++;
      if ({fetchReq, fetchAddr, regWriteEnable, flagWriteEnable} !== {1'b1, 16'h0001, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_next req=%b addr=%h we=%b fe=%b want 1 0001 0 0", fetchReq, fetchAddr, regWriteEnable, flagWriteEnable);
      end
   endtask

   task automatic test_immediates();
      exec_instr(16'h52FF);
      n_cmp++;
      if ({immediate, aluInputBMuxSelect, aluControl, regAddressA, regWriteEnable, flagWriteEnable} !== {16'hFFFF, 1'b1, 5'd0, 4'd2, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL addi imm=%h sel=%b alu=%0d ra=%0d we=%b fe=%b want ffff 1 0 2 1 1", immediate, aluInputBMuxSelect, aluControl, regAddressA, regWriteEnable, flagWriteEnable);
      end
      tick();
      exec_instr(16'h12FF);
      n_cmp++;
      if ({immediate, aluInputBMuxSelect, aluControl, regWriteEnable, flagWriteEnable} !== {16'h00FF, 1'b1, 5'd3, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL andi imm=%h sel=%b alu=%0d we=%b fe=%b want 00ff 1 3 1 0", immediate, aluInputBMuxSelect, aluControl, regWriteEnable, flagWriteEnable);
      end
      tick();
      exec_instr(16'hF4AB);
      n_cmp++;
      if ({immediate, aluInputBMuxSelect, aluControl, regAddressA, regWriteEnable, flagWriteEnable} !== {16'hAB00, 1'b1, 5'd7, 4'd4, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL lui imm=%h sel=%b alu=%0d ra=%0d we=%b fe=%b want ab00 1 7 4 1 0", immediate, aluInputBMuxSelect, aluControl, regAddressA, regWriteEnable, flagWriteEnable);
      end
      tick();
      n_cmp++;
      if (fetchAddr !== 16'h0004) begin
         n_bad++; $display("FAIL imm_pc got %h want 0004", fetchAddr);
      end
   endtask

   task automatic test_cmp();
      exec_instr(16'h01B2);
      n_cmp++;
      if ({regAddressA, regAddressB, aluControl, regWriteEnable, flagWriteEnable, aluInputBMuxSelect} !== {4'd1, 4'd2, 5'd2, 1'b0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL cmp_exec ra=%0d rb=%0d alu=%0d we=%b fe=%b sel=%b want 1 2 2 0 1 0", regAddressA, regAddressB, aluControl, regWriteEnable, flagWriteEnable, aluInputBMuxSelect);
      end
      tick();
      n_cmp++;
      if ({flagWriteEnable, regWriteEnable, fetchAddr} !== {1'b0, 1'b0, 16'h0005}) begin
         n_bad++; $display("FAIL cmp_pulse fe=%b we=%b addr=%h want 0 0 0005", flagWriteEnable, regWriteEnable, fetchAddr);
      end
   endtask

   task automatic test_stall();
      fetchValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (fetchReq !== 1'b1 || fetchAddr !== 16'h0005) begin
            n_bad++; $display("FAIL stall_hold cyc=%0d req=%b addr=%h want 1 0005", i, fetchReq, fetchAddr);
         end
         if (i < 4) tick();
      end
      fetchData = 16'h02D1; fetchValid = 1'b1;
      tick();
      fetchValid = 1'b0;
      n_cmp++;
      if (fetchReq !== 1'b0 || regWriteEnable !== 1'b0) begin
         n_bad++; $display("FAIL stall_decode req=%b we=%b want 0 0", fetchReq, regWriteEnable);
      end
      tick();
      n_cmp++;
      if ({regWriteEnable, flagWriteEnable, aluControl, regAddressA, regAddressB} !== {1'b1, 1'b0, 5'd6, 4'd2, 4'd1}) begin
         n_bad++; $display("FAIL stall_mov we=%b fe=%b alu=%0d ra=%0d rb=%0d want 1 0 6 2 1", regWriteEnable, flagWriteEnable, aluControl, regAddressA, regAddressB);
      end
      tick();
   endtask

   task automatic test_illegal();
      exec_instr(16'h7000);
      n_cmp++;
      if ({illegal, regWriteEnable, flagWriteEnable, aluControl} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         n_bad++; $display("FAIL illegal_exec ill=%b we=%b fe=%b alu=%0d want 1 0 0 0", illegal, regWriteEnable, flagWriteEnable, aluControl);
      end
      tick();
      n_cmp++;
      if (illegal !== 1'b1 || fetchAddr !== 16'h0007) begin
         n_bad++; $display("FAIL illegal_pc ill=%b addr=%h want 1 0007", illegal, fetchAddr);
      end
      exec_instr(16'h0351);
      n_cmp++;
      if (illegal !== 1'b1 || regWriteEnable !== 1'b1) begin
         n_bad++; $display("FAIL illegal_sticky ill=%b we=%b want 1 1", illegal, regWriteEnable);
      end
      tick();
   endtask

   task automatic test_run_drop();
      fetchData = 16'h0351; fetchValid = 1'b1;
      tick();
      run = 1'b0; fetchValid = 1'b0;
      tick();
      n_cmp++;
      if (regWriteEnable !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL rundrop_exec we=%b busy=%b want 1 1", regWriteEnable, busy);
      end
      tick();
      n_cmp++;
      if ({busy, fetchReq, regWriteEnable, fetchAddr} !== {1'b0, 1'b0, 1'b0, 16'h0009}) begin
         n_bad++; $display("FAIL rundrop_idle busy=%b req=%b we=%b addr=%h want 0 0 0 0009", busy, fetchReq, regWriteEnable, fetchAddr);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || fetchReq !== 1'b0) begin
         n_bad++; $display("FAIL rundrop_stay busy=%b req=%b want 0 0", busy, fetchReq);
      end
   endtask

   task automatic test_pc_wrap();
      force dut.pc_q = 16'hFFFF;
      tick();
      release dut.pc_q;
      run = 1'b1;
      tick();
      n_cmp++;
      if (fetchReq !== 1'b1 || fetchAddr !== 16'hFFFF) begin
         n_bad++; $display("FAIL wrap_fetch req=%b addr=%h want 1 ffff", fetchReq, fetchAddr);
      end
      exec_instr(16'h0000);
      n_cmp++;
      if ({regWriteEnable, flagWriteEnable, aluInputBMuxSelect, aluControl, illegal} !== {1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
         n_bad++; $display("FAIL nop_exec we=%b fe=%b sel=%b alu=%0d ill=%b want 0 0 0 0 1", regWriteEnable, flagWriteEnable, aluInputBMuxSelect, aluControl, illegal);
      end
      tick();
      n_cmp++;
      if (fetchAddr !== 16'h0000 || fetchReq !== 1'b1) begin
         n_bad++; $display("FAIL wrap_addr addr=%h req=%b want 0000 1", fetchAddr, fetchReq);
      end
   endtask

   task automatic test_reset_mid_exec();
      exec_instr(16'h0351);
      n_cmp++;
      if (regWriteEnable !== 1'b1) begin
         n_bad++; $display("FAIL rst_pre we=%b want 1", regWriteEnable);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({regWriteEnable, flagWriteEnable, busy, fetchReq, illegal} !== 5'b0) begin
         n_bad++; $display("FAIL rst_async we=%b fe=%b busy=%b req=%b ill=%b want 00000", regWriteEnable, flagWriteEnable, busy, fetchReq, illegal);
      end
      n_cmp++;
      if ({fetchAddr, regAddressA, aluControl} !== 25'd0) begin
         n_bad++; $display("FAIL rst_async_data addr=%h ra=%h alu=%h want 0", fetchAddr, regAddressA, aluControl);
      end
      tick();
      run = 1'b0; reset = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || fetchReq !== 1'b0 || fetchAddr !== 16'h0000) begin
         n_bad++; $display("FAIL rst_idle busy=%b req=%b addr=%h want 0 0 0000", busy, fetchReq, fetchAddr);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_immediates();
      test_cmp();
      test_stall();
      test_illegal();
      test_run_drop();
      test_pc_wrap();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
